// File: rtl/pid_pkg.sv
// Shared definitions for the PID controller and its PWM output stage.
package pid_pkg;

  localparam int D_WIDTH_DEF   = 16;
  localparam int Q_BITS_DEF    = 13;
  localparam int LIM_SHIFT_DEF = 12;

  typedef logic signed [D_WIDTH_DEF-1:0] cmd_t;

  typedef enum logic [1:0] {IDLE, START, RUN} pwm_state_t;

endpackage

// File: rtl/pwm_duty_calc.sv
// Combinational clamp/magnitude of a signed command and magnitude-to-duty scaling.
// Optional macro PWM_DRIVER_MIN_PULSE_EN snaps near-0 / near-full duties to the rails.
module pwm_duty_calc #(
  parameter int D_WIDTH   = 16,
  parameter int LIM_SHIFT = 12,
  parameter int CNT_WIDTH = 10,
  parameter int MIN_PULSE = 4
) (
  input  logic signed [D_WIDTH-1:0]   cmd,
  output logic        [LIM_SHIFT:0]   mag,
  output logic                        neg,
  output logic                        clip,
  input  logic        [LIM_SHIFT:0]   mag_s1,
  input  logic        [CNT_WIDTH-1:0] period_active,
  output logic        [CNT_WIDTH-1:0] duty
);

  localparam int PW = LIM_SHIFT + 1 + CNT_WIDTH;
  localparam logic signed [D_WIDTH-1:0] POS = D_WIDTH'(1 << LIM_SHIFT);
  localparam logic signed [D_WIDTH-1:0] NEG = -POS;

  if (MIN_PULSE < 0 || MIN_PULSE >= (1 << CNT_WIDTH)) begin : g_bad_min_pulse
    $error("pwm_duty_calc: MIN_PULSE out of range");
  end

  logic signed [D_WIDTH-1:0]   c;
  logic        [PW-1:0]        prod;
  logic        [CNT_WIDTH-1:0] scaled;

  always_comb begin
    c    = cmd;
    clip = 1'b0;
    if (cmd > POS) begin
      c    = POS;
      clip = 1'b1;
    end else if (cmd < NEG) begin
      c    = NEG;
      clip = 1'b1;
    end
  end

  assign neg = c[D_WIDTH-1];
  assign mag = (LIM_SHIFT+1)'(neg ? -c : c);

  // mag <= 1<<LIM_SHIFT, so the shifted product never exceeds period_active
  assign prod   = PW'(mag_s1) * PW'(period_active);
  assign scaled = CNT_WIDTH'(prod >> LIM_SHIFT);

`ifdef PWM_DRIVER_MIN_PULSE_EN
  always_comb begin
    duty = scaled;
    if (scaled < CNT_WIDTH'(MIN_PULSE))
      duty = '0;
    else if ({1'b0, scaled} + (CNT_WIDTH+1)'(MIN_PULSE) > {1'b0, period_active})
      duty = period_active;
  end
`else
  assign duty = scaled;
`endif

endmodule

// File: rtl/pwm_driver.sv
// PWM output stage for the PID loop: two-stage command pipeline, double-buffered duty,
// period counter FSM. Optional macro PWM_DRIVER_MIN_PULSE_EN enables sliver suppression.
module pwm_driver
  import pid_pkg::*;
#(
  parameter int D_WIDTH   = D_WIDTH_DEF,
  parameter int Q_BITS    = Q_BITS_DEF,
  parameter int LIM_SHIFT = LIM_SHIFT_DEF,
  parameter int CNT_WIDTH = 10,
  parameter int MIN_PULSE = 4
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        enable,
  input  logic        [CNT_WIDTH-1:0] period,
  input  logic signed [D_WIDTH-1:0]   cmd,
  input  logic                        cmd_valid,
  output logic                        pwm_out,
  output logic                        dir,
  output logic                        period_start,
  output logic                        sat,
  output logic        [CNT_WIDTH-1:0] duty_active
);

  if (Q_BITS < LIM_SHIFT || LIM_SHIFT >= D_WIDTH - 1) begin : g_bad_scale
    $error("pwm_driver: LIM_SHIFT inconsistent with command format");
  end

  logic                 s1_vld, s1_dir, s1_sat;
  logic [LIM_SHIFT:0]   s1_mag, c_mag;
  logic                 c_neg, c_clip;
  logic [CNT_WIDTH-1:0] duty_calc, duty_sh, duty_d;
  logic                 dir_sh, pending;
  logic [CNT_WIDTH-1:0] period_active, cnt, cnt_d;
  pwm_state_t           state, state_d;
  logic                 load, wrap, pwm_d;

  pwm_duty_calc #(
    .D_WIDTH  (D_WIDTH),
    .LIM_SHIFT(LIM_SHIFT),
    .CNT_WIDTH(CNT_WIDTH),
    .MIN_PULSE(MIN_PULSE)
  ) u_calc (
    .cmd          (cmd),
    .mag          (c_mag),
    .neg          (c_neg),
    .clip         (c_clip),
    .mag_s1       (s1_mag),
    .period_active(period_active),
    .duty         (duty_calc)
  );

  // Command pipeline and shadow keep running regardless of FSM state
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_vld  <= 1'b0;
      s1_mag  <= '0;
      s1_dir  <= 1'b0;
      s1_sat  <= 1'b0;
      duty_sh <= '0;
      dir_sh  <= 1'b0;
      sat     <= 1'b0;
      pending <= 1'b0;
    end else begin
      s1_vld <= cmd_valid;
      if (cmd_valid) begin
        s1_mag <= c_mag;
        s1_dir <= c_neg;
        s1_sat <= c_clip;
      end
      if (s1_vld) begin
        duty_sh <= duty_calc;
        dir_sh  <= s1_dir;
        sat     <= s1_sat;
      end
      // a write landing on a wrap edge stays pending for the next wrap
      if (s1_vld)    pending <= 1'b1;
      else if (load) pending <= 1'b0;
    end
  end

  assign wrap = (cnt == period_active - CNT_WIDTH'(1));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && period != '0) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      default: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          cnt_d = '0;
          if (period == '0) begin
            state_d = IDLE;
          end else begin
            state_d = START;
            load    = 1'b1;
          end
        end else begin
          state_d = RUN;
          cnt_d   = cnt + CNT_WIDTH'(1);
        end
      end
    endcase
    duty_d = (load && pending) ? duty_sh : duty_active;
    pwm_d  = (state_d != IDLE) && (cnt_d < duty_d);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      cnt           <= '0;
      period_active <= '0;
      duty_active   <= '0;
      dir           <= 1'b0;
      pwm_out       <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      duty_active <= duty_d;
      pwm_out     <= pwm_d;
      if (load) period_active <= period;
      if (load && pending) dir <= dir_sh;
    end
  end

  assign period_start = (state == START);

endmodule

// File: tb/tb_pwm_driver.sv
// Directed bench for pwm_driver: table of commands at period 100 plus hand sequences.
module tb_pwm_driver;

  logic               clk = 1'b0;
  logic               rstb = 1'b0;
  logic               enable = 1'b0;
  logic               cmd_valid = 1'b0;
  logic [9:0]         period = '0;
  logic signed [15:0] cmd = '0;
  logic               pwm_out, dir, period_start, sat;
  logic [9:0]         duty_active;

  int n_pass = 0;
  int n_chk  = 0;

`ifdef PWM_DRIVER_MIN_PULSE_EN
  localparam bit MP = 1'b1;
`else
  localparam bit MP = 1'b0;
`endif

  always #5 clk = ~clk;

  pwm_driver dut (
    .clk         (clk),
    .rstb        (rstb),
    .enable      (enable),
    .period      (period),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .pwm_out     (pwm_out),
    .dir         (dir),
    .period_start(period_start),
    .sat         (sat),
    .duty_active (duty_active)
  );

  typedef struct {
    logic signed [15:0] cmd;
    int                 duty;
    logic               dir;
    logic               sat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int lim);
    int i;
    i = 0;
    while (period_start !== 1'b1 && i < lim) begin
      tick();
      i++;
    end
    chk("period_start_seen", 32'(period_start), 1);
  endtask

  task automatic measure(input int n, output int hi, output int ps);
    hi = 0;
    ps = 0;
    repeat (n) begin
      if (pwm_out === 1'b1) hi++;
      if (period_start === 1'b1) ps++;
      tick();
    end
  endtask

  // two ticks; cmd is scrambled afterwards to show it is ignored without valid
  task automatic issue(input logic signed [15:0] v);
    cmd       = v;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd       = 16'sh5a5a;
    tick();
  endtask

  initial begin
    int hi, ps, last;

    vecs[0] = '{16'sd2048,  50,               1'b0, 1'b0};
    vecs[1] = '{-16'sd8192, 100,              1'b1, 1'b1};
    vecs[2] = '{16'sd1024,  25,               1'b0, 1'b0};
    vecs[3] = '{16'sd0,     0,                1'b0, 1'b0};
    vecs[4] = '{16'sd5000,  100,              1'b0, 1'b1};
    vecs[5] = '{-16'sd1,    0,                1'b1, 1'b0};
    vecs[6] = '{-16'sd3000, 73,               1'b1, 1'b0};
    vecs[7] = '{16'sd4096,  100,              1'b0, 1'b0};
    vecs[8] = '{16'sd82,    MP ? 0 : 2,       1'b0, 1'b0};
    vecs[9] = '{16'sd4014,  MP ? 100 : 97,    1'b0, 1'b0};

    tick();
    chk("rst_pwm",   32'(pwm_out), 0);
    chk("rst_dir",   32'(dir), 0);
    chk("rst_ps",    32'(period_start), 0);
    chk("rst_sat",   32'(sat), 0);
    chk("rst_duty",  32'(duty_active), 0);

    rstb   = 1'b1;
    enable = 1'b1;
    period = 10'd100;
    tick();
    chk("first_start", 32'(period_start), 1);
    chk("first_duty",  32'(duty_active), 0);

    for (int k = 0; k < 10; k++) begin
      issue(vecs[k].cmd);
      wait_start(300);
      chk($sformatf("v%0d_duty", k), 32'(duty_active), 32'(vecs[k].duty));
      chk($sformatf("v%0d_dir", k),  32'(dir), 32'(vecs[k].dir));
      chk($sformatf("v%0d_sat", k),  32'(sat), 32'(vecs[k].sat));
      measure(100, hi, ps);
      chk($sformatf("v%0d_high", k), 32'(hi), 32'(vecs[k].duty));
      chk($sformatf("v%0d_nps", k),  32'(ps), 1);
      chk($sformatf("v%0d_next", k), 32'(period_start), 1);
    end
    last = vecs[9].duty;

    // cmd two cycles before the wrap: shadow write coincides with the wrap edge
    repeat (98) tick();
    issue(16'sd1024);
    chk("late_wrap_ps",   32'(period_start), 1);
    chk("late_old_duty",  32'(duty_active), 32'(last));
    repeat (100) tick();
    chk("late_new_ps",    32'(period_start), 1);
    chk("late_new_duty",  32'(duty_active), 25);

    // period change mid-run waits for the wrap; duty is not rescaled
    period = 10'd10;
    measure(100, hi, ps);
    chk("pchg_old_nps",  32'(ps), 1);
    chk("pchg_old_high", 32'(hi), 25);
    chk("pchg_start",    32'(period_start), 1);
    measure(10, hi, ps);
    chk("pchg_new_nps",  32'(ps), 1);
    chk("pchg_noscale",  32'(hi), 10);
    chk("pchg_next",     32'(period_start), 1);
    issue(16'sd2048);
    wait_start(30);
    chk("p10_duty", 32'(duty_active), 5);
    measure(10, hi, ps);
    chk("p10_high", 32'(hi), 5);

    // asynchronous reset mid-period while pwm is high
    tick();
    tick();
    chk("pre_rst_pwm", 32'(pwm_out), 1);
    rstb   = 1'b0;
    enable = 1'b0;
    #2;
    chk("arst_pwm",  32'(pwm_out), 0);
    chk("arst_duty", 32'(duty_active), 0);
    chk("arst_dir",  32'(dir), 0);
    chk("arst_ps",   32'(period_start), 0);
    chk("arst_sat",  32'(sat), 0);
    tick();
    tick();
    rstb = 1'b1;
    measure(5, hi, ps);
    chk("post_rst_idle_ps",  32'(ps), 0);
    chk("post_rst_idle_pwm", 32'(hi), 0);
    enable = 1'b1;
    tick();
    chk("restart_ps",   32'(period_start), 1);
    chk("restart_duty", 32'(duty_active), 0);
    measure(10, hi, ps);
    chk("restart_nps",  32'(ps), 1);
    chk("restart_next", 32'(period_start), 1);

    // full duty, then disable and period=0 force idle
    issue(16'sd4096);
    wait_start(30);
    chk("full_duty", 32'(duty_active), 10);
    measure(10, hi, ps);
    chk("full_high", 32'(hi), 10);
    enable = 1'b0;
    tick();
    chk("dis_pwm", 32'(pwm_out), 0);
    measure(20, hi, ps);
    chk("dis_ps",  32'(ps), 0);
    chk("dis_hi",  32'(hi), 0);
    period = 10'd0;
    enable = 1'b1;
    measure(20, hi, ps);
    chk("p0_ps", 32'(ps), 0);
    chk("p0_hi", 32'(hi), 0);

    // period of one: every cycle is a period start
    period = 10'd1;
    tick();
    measure(5, hi, ps);
    chk("p1_ps",   32'(ps), 5);
    chk("p1_high", 32'(hi), 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
